// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a 2-flop input synchronizer and mid-bit sampling.
// Define UART_RX_PARITY_EN to expect one even-parity bit between D7 and the stop bit.
module uart_rx #(
  parameter int BIT_RATE = 9600,
  parameter int CLK_HZ   = 12_000_000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       RX,
  output logic [7:0] DATA,
  output logic       VALID,
  output logic       ERR,
  output logic       BUSY
);

  localparam int DIV   = CLK_HZ / BIT_RATE;
  localparam int HALF  = DIV / 2;
  localparam int CNT_W = $clog2(DIV);
`ifdef UART_RX_PARITY_EN
  localparam int LAST_BIT = 8;
`else
  localparam int LAST_BIT = 7;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_e;

  state_e state_q, state_d;

  logic             rxMeta_q, rxSync_q, rxPrev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
`ifdef UART_RX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic fallingEdge;
  logic halfTick;
  logic bitTick;

  assign fallingEdge = rxPrev_q & ~rxSync_q;
  assign halfTick    = (cnt_q == CNT_W'(HALF - 1));
  assign bitTick     = (cnt_q == CNT_W'(DIV - 1));

  // Synchronizer flops reset high so an idle line never looks like a start edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
      rxPrev_q <= 1'b1;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      rxMeta_q <= RX;
      rxSync_q <= rxMeta_q;
      rxPrev_q <= rxSync_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
`ifdef UART_RX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (fallingEdge) state_d = S_START;
      S_START:     if (halfTick) state_d = rxSync_q ? S_IDLE : S_DATA;
      S_DATA:      if (bitTick && bit_q == 4'(LAST_BIT)) state_d = S_STOP;
      S_STOP:      if (bitTick) state_d = rxSync_q ? S_IDLE : S_WAIT_HIGH;
      S_WAIT_HIGH: if (rxSync_q) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Leaving STOP at the stop-bit midpoint leaves half a bit to catch the next start edge.
  always_comb begin
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
      end
      S_START: begin
        if (halfTick) cnt_d = '0;
      end
      S_DATA: begin
        if (bitTick) begin
          cnt_d = '0;
          bit_d = bit_q + 4'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_q == 4'd8) parity_d = rxSync_q;
          else               shift_d  = {rxSync_q, shift_q[7:1]};
`else
          shift_d = {rxSync_q, shift_q[7:1]};
`endif
        end
      end
      S_STOP: begin
        if (bitTick) begin
          cnt_d = '0;
          if (!rxSync_q) begin
            err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (^{shift_q, parity_q}) begin
            err_d = 1'b1;
`endif
          end else begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end
        end
      end
      S_WAIT_HIGH: cnt_d = '0;
      default:     cnt_d = '0;
    endcase
  end

  assign DATA  = data_q;
  assign VALID = valid_q;
  assign ERR   = err_q;
  assign BUSY  = (state_q != S_IDLE) || fallingEdge;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized scoreboard bench for uart_rx; frames are predicted from the
// serial format alone and popped by an independent monitor on every VALID/ERR pulse.
module tb_uart_rx;

  localparam int  CLK_HZ   = 12_000_000;
  localparam int  BIT_RATE = 9600;
  localparam int  DIV      = CLK_HZ / BIT_RATE;
  localparam int  HALF     = DIV / 2;
`ifdef UART_RX_PARITY_EN
  localparam bit  PARITY_ON = 1'b1;
  localparam int  NBITS     = 10;
`else
  localparam bit  PARITY_ON = 1'b0;
  localparam int  NBITS     = 9;
`endif
  localparam longint LAT = 2 + HALF + NBITS * DIV;

  logic       CLK;
  logic       RST_N;
  logic       RX;
  logic [7:0] DATA;
  logic       VALID;
  logic       ERR;
  logic       BUSY;

  typedef struct {
    bit         isErr;
    logic [7:0] data;
    longint     edgeCycle;
  } exp_t;

  exp_t       sb[$];
  exp_t       popped;
  longint     cycle = 0;
  longint     lat;
  logic [7:0] lastGood = 8'h00;
  int         errSeen = 0;
  int         compared = 0;
  int         failed = 0;

  uart_rx #(.BIT_RATE(BIT_RATE), .CLK_HZ(CLK_HZ)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .RX   (RX),
    .DATA (DATA),
    .VALID(VALID),
    .ERR  (ERR),
    .BUSY (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic driveBit(input logic b, input int n);
    RX = b;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Reference model: a frame is good only with a high stop bit and, when parity is on, an even count of ones.
  task automatic applyStimulus(input logic [7:0] d, input bit parityBit, input bit stopBit, input int stopLen);
    exp_t x;
    x.isErr     = !stopBit || (PARITY_ON && ((($countones(d) + int'(parityBit)) % 2) != 0));
    x.data      = d;
    x.edgeCycle = cycle;
    sb.push_back(x);
    driveBit(1'b0, DIV);
    for (int i = 0; i < 8; i++) driveBit(d[i], DIV);
`ifdef UART_RX_PARITY_EN
    driveBit(parityBit, DIV);
`endif
    driveBit(stopBit, stopLen);
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge CLK);
      #1;
      n++;
    end
    checkOutput("drainInTime", sb.size(), 0);
  endtask

  // Monitor: every output pulse must match the oldest outstanding prediction.
  always @(negedge CLK) begin
    if (RST_N && (VALID || ERR)) begin
      checkOutput("validErrExclusive", {31'b0, VALID & ERR}, 0);
      if (sb.size() == 0) begin
        checkOutput("unexpectedEvent", {31'b0, ERR}, {31'b0, ~VALID});
      end else begin
        popped = sb.pop_front();
        checkOutput("eventIsErr", {31'b0, ERR}, {31'b0, popped.isErr});
        lat = cycle - popped.edgeCycle;
        compared++;
        if (lat < LAT - 2 || lat > LAT + 2) begin
          failed++;
          $display("[TB] FAIL latency: got %0d expected %0d +-2", lat, LAT);
        end
        if (popped.isErr) begin
          checkOutput("dataHeldOnErr", {24'b0, DATA}, {24'b0, lastGood});
        end else begin
          checkOutput("dataOnValid", {24'b0, DATA}, {24'b0, popped.data});
          lastGood = popped.data;
        end
      end
      if (ERR) errSeen++;
    end
  end

  initial begin
    #(200_000 * 10);
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         errBefore;
    logic [7:0] r;
    RX    = 1'b1;
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("resetData", {24'b0, DATA}, 0);
    checkOutput("resetValid", {31'b0, VALID}, 0);
    checkOutput("resetErr", {31'b0, ERR}, 0);
    checkOutput("resetBusy", {31'b0, BUSY}, 0);
    RST_N = 1'b1;
    driveBit(1'b1, $urandom_range(10, 40));

    $display("[TB] frame 0x41");
    applyStimulus(8'h41, 1'b0, 1'b1, DIV);
    waitDrain(100);
    checkOutput("data41", {24'b0, DATA}, 32'h41);

`ifdef UART_RX_PARITY_EN
    $display("[TB] frame 0x41 with wrong parity");
    applyStimulus(8'h41, 1'b1, 1'b1, DIV);
    waitDrain(100);
    checkOutput("dataAfterParityErr", {24'b0, DATA}, 32'h41);
`endif

    $display("[TB] start-bit glitch");
    driveBit(1'b0, 300);
    checkOutput("glitchBusyHigh", {31'b0, BUSY}, 1);
    driveBit(1'b1, HALF + 50);
    checkOutput("glitchBusyLow", {31'b0, BUSY}, 0);
    checkOutput("glitchData", {24'b0, DATA}, 32'h41);

    $display("[TB] frame 0x55 with low stop bit then break");
    errBefore = errSeen;
    applyStimulus(8'h55, 1'b0, 1'b0, DIV);
    driveBit(1'b0, 5000);
    checkOutput("busyDuringBreak", {31'b0, BUSY}, 1);
    driveBit(1'b1, 10);
    checkOutput("busyAfterBreak", {31'b0, BUSY}, 0);
    checkOutput("oneErrForBreak", errSeen - errBefore, 1);
    checkOutput("dataAfterBreak", {24'b0, DATA}, 32'h41);
    waitDrain(100);

    $display("[TB] back-to-back 0x00, 0xFF");
    applyStimulus(8'h00, 1'b0, 1'b1, DIV);
    applyStimulus(8'hFF, 1'b0, 1'b1, DIV);
    waitDrain(100);
    checkOutput("dataFF", {24'b0, DATA}, 32'hFF);

    $display("[TB] reset during D3 of 0xA5");
    driveBit(1'b1, $urandom_range(5, 50));
    driveBit(1'b0, DIV);
    driveBit(1'b1, DIV);
    driveBit(1'b0, DIV);
    driveBit(1'b1, DIV);
    driveBit(1'b0, $urandom_range(100, DIV - 100));
    RST_N = 1'b0;
    #1;
    checkOutput("midResetData", {24'b0, DATA}, 0);
    checkOutput("midResetValid", {31'b0, VALID}, 0);
    checkOutput("midResetErr", {31'b0, ERR}, 0);
    checkOutput("midResetBusy", {31'b0, BUSY}, 0);
    lastGood = 8'h00;
    driveBit(1'b1, 5);
    RST_N = 1'b1;
    driveBit(1'b1, $urandom_range(5, 50));
    checkOutput("postResetBusy", {31'b0, BUSY}, 0);
    applyStimulus(8'h3C, 1'b0, 1'b1, DIV);
    waitDrain(100);
    checkOutput("data3C", {24'b0, DATA}, 32'h3C);

`ifndef UART_RX_PARITY_EN
    r = 8'($urandom);
    $display("[TB] random frame 0x%0h", r);
    driveBit(1'b1, $urandom_range(1, 30));
    applyStimulus(r, ^r, 1'b1, DIV);
    waitDrain(100);
    checkOutput("dataRandom", {24'b0, DATA}, {24'b0, r});
`else
    r = 8'h00;
`endif

    driveBit(1'b1, 20);
    checkOutput("scoreboardEmpty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
